// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register slave:
//   - response codes driven on BRESP / RRESP
//   - state types for the write and read channel FSMs
//   - a byte-lane merge helper used when committing a strobed write
// No ports (package).
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_strobes(input logic [31:0] old_word,
                                                  input logic [31:0] new_word,
                                                  input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// ---------------------------------------------------------------------------
// axi_lite_addr_decode
// Maps a byte address onto a word index of the register array.
//   addr      in   AW        byte address from AW or AR channel
//   idx       out  IDX_W     word index (address bits [1:0] are ignored)
//   in_range  out  1         address falls inside the array window
// The offset from the base wraps modulo 2^AW, so addresses below the base
// become huge offsets and are reported out of range.
// ---------------------------------------------------------------------------
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          NUM_WORDS = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic [AW-1:0]    addr,
    output logic [IDX_W-1:0] idx,
    output logic             in_range
);

    localparam logic [AW-1:0] BASE_VEC = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LIMIT    = AW'(4 * NUM_WORDS);

    logic [AW-1:0] off;

    always_comb begin
        off      = addr - BASE_VEC;
        in_range = (off < LIMIT);
        idx      = off[IDX_W+1:2];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite slave backed by a word-addressed register array, with a side
// port so scan logic can snoop words and observe committed writes.
// One outstanding write and one outstanding read; channels are independent.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET     clock, synchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B* write address / data / response channels
//   S_AXI_AR*, S_AXI_R*           read address / data channels
//   snoop_idx / snoop_data        combinational view of array[snoop_idx]
//   wr_pulse / wr_idx             one-cycle strobe and index per in-range write
// ---------------------------------------------------------------------------
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_NUM_WORDS        = 16,
    parameter int unsigned C_BASE_ADDR        = 0,
    localparam int         IDX_W              = $clog2(C_NUM_WORDS)
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [IDX_W-1:0]                snoop_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   snoop_data,
    output logic                            wr_pulse,
    output logic [IDX_W-1:0]                wr_idx
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    // Protection bits carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Address decoders for both address channels.
    logic [IDX_W-1:0] aw_dec_idx;
    logic             aw_dec_ok;
    logic [IDX_W-1:0] ar_dec_idx;
    logic             ar_dec_ok;

    axi_lite_addr_decode #(
        .AW        (C_S_AXI_ADDR_WIDTH),
        .NUM_WORDS (C_NUM_WORDS),
        .BASE_ADDR (C_BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_aw_decode (
        .addr     (S_AXI_AWADDR),
        .idx      (aw_dec_idx),
        .in_range (aw_dec_ok)
    );

    axi_lite_addr_decode #(
        .AW        (C_S_AXI_ADDR_WIDTH),
        .NUM_WORDS (C_NUM_WORDS),
        .BASE_ADDR (C_BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_ar_decode (
        .addr     (S_AXI_ARADDR),
        .idx      (ar_dec_idx),
        .in_range (ar_dec_ok)
    );

    // State and storage
    wr_state_t        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             aw_ok_q, aw_ok_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [DW-1:0]    mem_q [C_NUM_WORDS];
    logic [DW-1:0]    mem_d [C_NUM_WORDS];

    rd_state_t        rd_state_q, rd_state_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic [IDX_W-1:0] cm_idx;
    logic             cm_ok;
    logic [DW-1:0]    cm_data;
    logic [SW-1:0]    cm_strb;

    // Readies come from registered state only (reset forces them low), so
    // they never depend on any VALID input.
    assign S_AXI_AWREADY = !S_AXI_ARESET &&
                           ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_W));
    assign S_AXI_WREADY  = !S_AXI_ARESET &&
                           ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_AW));
    assign S_AXI_ARREADY = !S_AXI_ARESET && (rd_state_q == RD_IDLE);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign S_AXI_BVALID = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = (rd_state_q == RD_RESP);
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign snoop_data   = mem_q[snoop_idx];
    assign wr_pulse     = wr_pulse_q;
    assign wr_idx       = wr_idx_q;

    // Write channel: the commit happens on the edge where the second of the
    // AW/W handshakes completes, taking whichever half is arriving live and
    // the other half from its latch. BVALID follows one cycle later.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        aw_ok_d    = aw_ok_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = '0;
        mem_d      = mem_q;
        commit     = 1'b0;
        cm_idx     = aw_idx_q;
        cm_ok      = aw_ok_q;
        cm_data    = wdata_q;
        cm_strb    = wstrb_q;

        if (aw_hs) begin
            cm_idx = aw_dec_idx;
            cm_ok  = aw_dec_ok;
        end
        if (w_hs) begin
            cm_data = S_AXI_WDATA;
            cm_strb = S_AXI_WSTRB;
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_idx_d   = aw_dec_idx;
                    aw_ok_d    = aw_dec_ok;
                    wr_state_d = WR_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d    = S_AXI_WDATA;
                    wstrb_d    = S_AXI_WSTRB;
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        if (commit) begin
            wr_state_d = WR_RESP;
            bresp_d    = cm_ok ? RESP_OKAY : RESP_SLVERR;
            if (cm_ok) begin
                mem_d[cm_idx] = apply_strobes(mem_q[cm_idx], cm_data, cm_strb);
                wr_pulse_d    = 1'b1;
                wr_idx_d      = cm_idx;
            end
        end
    end

    // Read channel: data is sampled from the array on the AR handshake, so a
    // write committing on the same edge is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = ar_dec_ok ? mem_q[ar_dec_idx] : '0;
                    rresp_d    = ar_dec_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WR_IDLE;
            aw_idx_q   <= '0;
            aw_ok_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < C_NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            aw_ok_q    <= aw_ok_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < C_NUM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
